// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types and constants for the byte-wide memory controller.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int         MEM_ADDR_W = 18;
  localparam logic [1:0] IO_REGION  = 2'b11;

  typedef enum logic {
    OWN_DC = 1'b0,
    OWN_IC = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } inflight_t;

  localparam inflight_t c_inflight_idle = '{valid: 1'b0, owner: OWN_DC};

  // The two top address bits select the IO region.
  function automatic logic is_io_addr(input logic [1:0] top_bits);
    return top_bits == IO_REGION;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_inflight_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mem_inflight_pipe
// Brief    : Fixed-depth shift register of in-flight {valid, owner} tags.
// Revision : 1.0 - initial release
// ============================================================================
module mem_inflight_pipe
  import mem_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  inflight_t din,
  output inflight_t dout,
  output logic      busy
);

  inflight_t r_stage [DEPTH];

  // Advances every cycle; the global enable only gates what enters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= c_inflight_idle;
      end
    end else begin
      r_stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      busy = busy | r_stage[i].valid;
    end
  end

  assign dout = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_ctrl
// Brief    : Byte-wide RAM/IO controller arbitrating dcache (priority) and icache.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int RAM_LATENCY = 1           // legal range 1..3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              dc_get_en,
  input  logic              dc_write_mode,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [7:0]        dc_data,
  input  logic              ic_get_en,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              io_buffer_full,
  input  logic [7:0]        ram_din,
  output logic              dc_out_en,
  output logic              ic_out_en,
  output logic [7:0]        mem_content,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  output logic              idle
);

  logic              w_dc_blocked;
  logic              w_grant_dc;
  logic              w_grant_ic;
  logic              w_grant;
  logic              w_pipe_busy;
  inflight_t         w_issue;
  inflight_t         w_done;
  logic [ADDR_W-1:0] r_last_addr;

  // A stalled IO write also holds off the icache so ordering is preserved.
  always_comb begin
    w_dc_blocked = dc_write_mode && io_buffer_full &&
                   is_io_addr(dc_addr[ADDR_W-1 -: 2]);
    w_grant_dc   = rst_n && rdy && dc_get_en && !w_dc_blocked;
    w_grant_ic   = rst_n && rdy && !dc_get_en && ic_get_en;
    w_grant      = w_grant_dc || w_grant_ic;
  end

  always_comb begin
    ram_addr = r_last_addr;
    ram_wr   = 1'b0;
    ram_dout = 8'h00;
    if (!rst_n) begin
      ram_addr = '0;
    end else if (w_grant_dc) begin
      ram_addr = dc_addr;
      ram_wr   = dc_write_mode;
      ram_dout = dc_data;
    end else if (w_grant_ic) begin
      ram_addr = ic_addr;
    end
  end

  // Holding the address when idle keeps the bus quiet between accesses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_addr <= '0;
    end else if (w_grant) begin
      r_last_addr <= ram_addr;
    end
  end

  always_comb begin
    w_issue.valid = w_grant;
    w_issue.owner = w_grant_dc ? OWN_DC : OWN_IC;
  end

  mem_inflight_pipe #(
    .DEPTH (RAM_LATENCY)
  ) u_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (w_issue),
    .dout  (w_done),
    .busy  (w_pipe_busy)
  );

  assign dc_out_en   = w_done.valid && (w_done.owner == OWN_DC);
  assign ic_out_en   = w_done.valid && (w_done.owner == OWN_IC);
  assign mem_content = ram_din;
  assign idle        = !rst_n || (!w_pipe_busy && !w_grant);

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_ctrl
// Brief    : Drives mem_ctrl at latencies 1..3 in lockstep against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;
  import mem_pkg::*;

  localparam int AW     = MEM_ADDR_W;
  localparam int NDUT   = 3;
  localparam int MEM_SZ = 1 << AW;
  localparam int MAXC   = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rdy, dc_get_en, dc_write_mode, ic_get_en, io_buffer_full;
  logic [AW-1:0] dc_addr, ic_addr;
  logic [7:0]    dc_data;

  logic [7:0]    ram_din     [NDUT];
  logic          dc_out_en   [NDUT];
  logic          ic_out_en   [NDUT];
  logic [7:0]    mem_content [NDUT];
  logic [AW-1:0] ram_addr    [NDUT];
  logic          ram_wr      [NDUT];
  logic [7:0]    ram_dout    [NDUT];
  logic          idle        [NDUT];

  mem_ctrl #(.ADDR_W(AW), .RAM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .dc_get_en(dc_get_en),
    .dc_write_mode(dc_write_mode), .dc_addr(dc_addr), .dc_data(dc_data),
    .ic_get_en(ic_get_en), .ic_addr(ic_addr), .io_buffer_full(io_buffer_full),
    .ram_din(ram_din[0]), .dc_out_en(dc_out_en[0]), .ic_out_en(ic_out_en[0]),
    .mem_content(mem_content[0]), .ram_addr(ram_addr[0]), .ram_wr(ram_wr[0]),
    .ram_dout(ram_dout[0]), .idle(idle[0]));

  mem_ctrl #(.ADDR_W(AW), .RAM_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .dc_get_en(dc_get_en),
    .dc_write_mode(dc_write_mode), .dc_addr(dc_addr), .dc_data(dc_data),
    .ic_get_en(ic_get_en), .ic_addr(ic_addr), .io_buffer_full(io_buffer_full),
    .ram_din(ram_din[1]), .dc_out_en(dc_out_en[1]), .ic_out_en(ic_out_en[1]),
    .mem_content(mem_content[1]), .ram_addr(ram_addr[1]), .ram_wr(ram_wr[1]),
    .ram_dout(ram_dout[1]), .idle(idle[1]));

  mem_ctrl #(.ADDR_W(AW), .RAM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .dc_get_en(dc_get_en),
    .dc_write_mode(dc_write_mode), .dc_addr(dc_addr), .dc_data(dc_data),
    .ic_get_en(ic_get_en), .ic_addr(ic_addr), .io_buffer_full(io_buffer_full),
    .ram_din(ram_din[2]), .dc_out_en(dc_out_en[2]), .ic_out_en(ic_out_en[2]),
    .mem_content(mem_content[2]), .ram_addr(ram_addr[2]), .ram_wr(ram_wr[2]),
    .ram_dout(ram_dout[2]), .idle(idle[2]));

  function automatic logic [7:0] init_byte(input int a);
    logic [31:0] x;
    if (a >= 32'h1230 && a <= 32'h1233) begin
      x = 32'hA0 + (a - 32'h1230);
    end else begin
      x = (a * 32'd37) ^ (a >> 8) ^ 32'h5C;
    end
    return x[7:0];
  endfunction

  // RAM/IO environment: one memory per DUT, read data delayed by its latency.
  logic [7:0] env_mem [NDUT][MEM_SZ];
  initial begin : env
    logic [AW-1:0] ea [NDUT];
    logic          ew [NDUT];
    logic [7:0]    ed [NDUT];
    logic [7:0]    er [NDUT];
    logic [7:0]    hist [NDUT][3];
    for (int k = 0; k < NDUT; k++) begin
      ram_din[k] = 8'h00;
      for (int j = 0; j < 3; j++) hist[k][j] = 8'h00;
      for (int i = 0; i < MEM_SZ; i++) env_mem[k][i] = init_byte(i);
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
        ea[k] = ram_addr[k];
        ew[k] = ram_wr[k];
        ed[k] = ram_dout[k];
        er[k] = env_mem[k][ea[k]];
      end
      @(posedge clk);
      for (int k = 0; k < NDUT; k++) begin
        if (ew[k]) env_mem[k][ea[k]] = ed[k];
        hist[k][2] = hist[k][1];
        hist[k][1] = hist[k][0];
        hist[k][0] = er[k];
        ram_din[k] = hist[k][k];
      end
    end
  end

  // Reference model: issue log indexed by cycle, plus a shadow memory.
  logic [7:0]    ref_mem [MEM_SZ];
  bit            iss_v   [MAXC];
  bit            iss_ic  [MAXC];
  bit            iss_rd  [MAXC];
  logic [7:0]    iss_d   [MAXC];
  logic [AW-1:0] m_last_addr;
  int            cyc;
  bit            g_dc, g_ic;
  int            checks, errors;

  task automatic chk(input int k, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s lat%0d cyc%0d: observed %0h expected %0h", tag, k + 1, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit ry, input bit dce, input bit dcw,
                      input logic [AW-1:0] dca, input logic [7:0] dcd,
                      input bit ice, input logic [AW-1:0] ica, input bit iof);
    bit            blocked, v, vic, busy;
    int            c;
    logic [AW-1:0] ea;
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_budget: observed %0d expected below %0d", cyc, MAXC - 1);
      $fatal(1, "cycle budget exhausted");
    end
    rst_n = r; rdy = ry; dc_get_en = dce; dc_write_mode = dcw; dc_addr = dca;
    dc_data = dcd; ic_get_en = ice; ic_addr = ica; io_buffer_full = iof;
    blocked = dcw && iof && (dca[AW-1 -: 2] == 2'b11);
    g_dc    = r && ry && dce && !blocked;
    g_ic    = r && ry && !dce && ice;
    ea      = !r ? '0 : (g_dc ? dca : (g_ic ? ica : m_last_addr));
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      c    = cyc - (k + 1);
      v    = (c >= 0) ? iss_v[c] : 1'b0;
      vic  = (c >= 0) ? iss_ic[c] : 1'b0;
      busy = 1'b0;
      for (int j = 1; j <= k + 1; j++) begin
        if (cyc - j >= 0 && iss_v[cyc - j]) busy = 1'b1;
      end
      chk(k, "ram_addr", 32'(ram_addr[k]), 32'(ea));
      chk(k, "ram_wr", 32'(ram_wr[k]), 32'(g_dc && dcw));
      if (!r) chk(k, "ram_dout_rst", 32'(ram_dout[k]), 32'h0);
      else if (g_dc && dcw) chk(k, "ram_dout", 32'(ram_dout[k]), 32'(dcd));
      chk(k, "dc_out_en", 32'(dc_out_en[k]), 32'(v && !vic));
      chk(k, "ic_out_en", 32'(ic_out_en[k]), 32'(v && vic));
      if (v && iss_rd[c]) chk(k, "mem_content", 32'(mem_content[k]), 32'(iss_d[c]));
      chk(k, "idle", 32'(idle[k]), 32'(!r || (!busy && !g_dc && !g_ic)));
    end
    iss_v[cyc]  = g_dc || g_ic;
    iss_ic[cyc] = g_ic;
    iss_rd[cyc] = g_ic || (g_dc && !dcw);
    iss_d[cyc]  = ref_mem[ea];
    if (g_dc && dcw) ref_mem[dca] = dcd;
    if (g_dc || g_ic) m_last_addr = ea;
    if (!r) begin
      for (int i = 0; i <= cyc; i++) iss_v[i] = 1'b0;
      m_last_addr = '0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_step();
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 8'h00, 1'b0, '0, 1'b0);
  endtask

  initial begin : main
    int            n, t;
    bit            dc_done, granted, r, ry, dce, dcw, ice, iof;
    logic [AW-1:0] dca, ic_ptr;
    checks = 0; errors = 0; cyc = 0; m_last_addr = '0;
    for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = init_byte(i);
    for (int i = 0; i < MAXC; i++) iss_v[i] = 1'b0;

    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, '0, 8'h00, 1'b0, '0, 1'b0);
    repeat (2) idle_step();

    // dcache 4-byte read burst at 0x01230
    n = 0; t = 0;
    while (n < 4 && t < 20) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, AW'(32'h1230 + n), 8'h00, 1'b0, '0, 1'b0);
      if (g_dc) n++;
      t++;
    end
    chk(0, "burst_rd_count", n, 4);
    repeat (3) idle_step();

    // icache fetch with a dcache write on its second byte
    n = 0; t = 0; dc_done = 1'b0;
    while (n < 4 && t < 20) begin
      step(1'b1, 1'b1, (n == 1) && !dc_done, 1'b1, AW'(32'h200), 8'h5A,
           1'b1, AW'(32'h100 + n), 1'b0);
      if (g_dc) dc_done = 1'b1;
      if (g_ic) n++;
      t++;
    end
    chk(0, "ic_fetch_count", n, 4);
    chk(0, "dc_preempt_done", 32'(dc_done), 32'h1);
    repeat (3) idle_step();

    // IO write stalled by a full buffer, icache also waiting
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, AW'(32'h30000), 8'h41, 1'b1, AW'(32'h300), 1'b1);
    t = 0; granted = 1'b0;
    while (!granted && t < 5) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, AW'(32'h30000), 8'h41, 1'b0, '0, 1'b0);
      granted = g_dc;
      t++;
    end
    chk(0, "io_write_granted", 32'(granted), 32'h1);
    repeat (3) idle_step();

    // rdy dropped for two cycles mid-burst
    n = 0; t = 0;
    while (n < 6 && t < 30) begin
      step(1'b1, !(t == 2 || t == 3), 1'b1, 1'b0, AW'(32'h2000 + n), 8'h00, 1'b0, '0, 1'b0);
      if (g_dc) n++;
      t++;
    end
    chk(0, "rdy_burst_count", n, 6);
    repeat (3) idle_step();

    // reset while accesses are in flight, with a write presented
    step(1'b1, 1'b1, 1'b1, 1'b0, AW'(32'h2100), 8'h00, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, AW'(32'h2101), 8'h00, 1'b0, '0, 1'b0);
    repeat (2) step(1'b0, 1'b1, 1'b1, 1'b1, AW'(32'h2200), 8'hFF, 1'b1, AW'(32'h400), 1'b0);
    repeat (4) idle_step();

    // 8-byte write-back then 4-byte read, continuous
    n = 0; t = 0;
    while (n < 12 && t < 40) begin
      if (n < 8) step(1'b1, 1'b1, 1'b1, 1'b1, AW'(32'h4000 + n), 8'($urandom), 1'b0, '0, 1'b0);
      else       step(1'b1, 1'b1, 1'b1, 1'b0, AW'(32'h4000 + n - 8), 8'h00, 1'b0, '0, 1'b0);
      if (g_dc) n++;
      t++;
    end
    chk(0, "wb_rd_count", n, 12);
    repeat (4) idle_step();

    // randomized mixed traffic
    ic_ptr = AW'(32'h800);
    repeat (400) begin
      r   = ($urandom_range(0, 63) != 0);
      ry  = ($urandom_range(0, 7) != 0);
      dce = ($urandom_range(0, 1) == 1);
      dcw = ($urandom_range(0, 1) == 1);
      ice = ($urandom_range(0, 1) == 1);
      iof = ($urandom_range(0, 3) == 0);
      dca = ($urandom_range(0, 1) == 1) ? AW'(32'h30000 + $urandom_range(0, 15))
                                        : AW'(32'h5000 + $urandom_range(0, 63));
      step(r, ry, dce, dcw, dca, 8'($urandom), ice, ic_ptr, iof);
      if (g_ic) ic_ptr = ic_ptr + 1'b1;
    end
    repeat (4) idle_step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
